// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_seq_ha_cell.sv
// Half-adder cell: the shared one-bit datapath primitive.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder sequencer, LSB first, WIDTH+2 cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             cmsb_q, cmsb_d;
`endif

  logic s1, c1, sbit, c2;

  ha_cell u_ha1 (.x(a_q[0]), .y(b_q[0]),  .s(s1),   .c(c1));
  ha_cell u_ha2 (.x(s1),     .y(carry_q), .s(sbit), .c(c2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    cmsb_d  = cmsb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = CW'(WIDTH);
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sum_d   = {sbit, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c1 | c2;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last bit: carry_q is still the carry into the MSB here.
          state_d = DONE;
          cout_d  = c1 | c2;
          done_d  = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          cmsb_d  = carry_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= cmsb_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = cmsb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed plus randomized bench for serial_add_seq against an arithmetic reference model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [W:0] full;
    logic       v;
    full = {1'b0, aa} + {1'b0, bb};
    v    = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
    return {v, full};
  endfunction

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  // One full operation; poke_at > 0 re-asserts start mid-SHIFT with other operands.
  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int poke_at);
    int n;
    int extra_done;
    wait_ready();
    a = aa;
    b = bb;
    start = 1'b1;
    exp_q.push_back(model(aa, bb));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 1;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, "_ready_after_accept"}, 32'(ready), 32'd0);
    while (done !== 1'b1 && n < 40) begin
      if (n == poke_at) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_done_latency"}, 32'(n), 32'(W + 1));
    chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    extra_done = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    chk({tag, "_no_extra_done"}, 32'(extra_done), 32'd0);
  endtask

  initial begin
    int dones;
    int last_done;
    int bad_period;
    int overlap;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op("zero", 8'h00, 8'h00, 0);
    run_op("5a_3c", 8'h5A, 8'h3C, 0);
    run_op("ff_01", 8'hFF, 8'h01, 0);
    run_op("ignored_start", 8'h0F, 8'h71, 3);

    // Reset in the middle of SHIFT discards the operation.
    wait_ready();
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (W + 6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 8'hC3, 8'h5E, 0);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      run_op("rand", ra, rb, 0);
    end

    // Back-to-back with start held high.
    wait_ready();
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    dones = 0;
    last_done = -1;
    bad_period = 0;
    overlap = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (done === 1'b1 && ready === 1'b1) overlap++;
      if (done === 1'b1) begin
        dones++;
        exp_q.push_back(model(8'h80, 8'h80));
        check_result("held");
        if (last_done >= 0 && (t - last_done) != W + 2) bad_period++;
        last_done = t;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(dones >= 4), 32'd1);
    chk("held_period", 32'(bad_period), 32'd0);
    chk("held_done_ready_overlap", 32'(overlap), 32'd0);
    wait_ready();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
